// File: rtl/vcla_mp_seq.sv
// rtl/vcla_mp_seq.sv - multi-precision add/subtract sequencer driving a 64-bit carry-lookahead adder
// Operands are walked LSB limb first through one VCLA_64, chaining the limb carry through c_q.

module VCLA_64 (
   input  logic [63:0] in_A,
   input  logic [63:0] in_B,
   input  logic        in_CI,
   output logic [63:0] out_S,
   output logic        out_CO
);
   logic [63:0] g;
   logic [63:0] p;
   logic [64:0] c;
   logic        grp_g;
   logic        grp_p;

   // 4-bit lookahead groups; the group generate/propagate bypasses the in-group chain
   always_comb begin
      g     = in_A & in_B;
      p     = in_A ^ in_B;
      c     = '0;
      c[0]  = in_CI;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int grp = 0; grp < 16; grp++) begin
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int i = 0; i < 4; i++) begin
            grp_g = g[grp*4+i] | (p[grp*4+i] & grp_g);
            grp_p = grp_p & p[grp*4+i];
         end
         for (int i = 0; i < 3; i++) begin
            c[grp*4+i+1] = g[grp*4+i] | (p[grp*4+i] & c[grp*4+i]);
         end
         c[grp*4+4] = grp_g | (grp_p & c[grp*4]);
      end
      out_S  = p ^ c[63:0];
      out_CO = c[64];
   end
endmodule

module vcla_mp_seq #(
   parameter int NWORDS = 4
) (
   input  logic                   in_CLK,
   input  logic                   in_RST,
   input  logic                   in_VALID,
   output logic                   out_READY,
   input  logic [64*NWORDS-1:0]   in_A,
   input  logic [64*NWORDS-1:0]   in_B,
   input  logic                   in_CI,
   input  logic                   in_SUB,
   output logic [64*NWORDS-1:0]   out_S,
   output logic                   out_CO,
   output logic                   out_OV,
   output logic                   out_VALID,
   input  logic                   in_READY
);
   localparam int W  = 64 * NWORDS;
   localparam int KW = $clog2(NWORDS);
   localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    bx_q;
   logic [W-1:0]    s_q;
   logic [KW-1:0]   k_q;
   logic            c_q;
   logic            ov_q;
   logic            valid_q;

   logic [63:0]     a_limb;
   logic [63:0]     bx_limb;
   logic [63:0]     sum_limb;
   logic            co_limb;

   assign a_limb  = a_q[{k_q, 6'd0} +: 64];
   assign bx_limb = bx_q[{k_q, 6'd0} +: 64];

   VCLA_64 u_cla (
      .in_A   (a_limb),
      .in_B   (bx_limb),
      .in_CI  (c_q),
      .out_S  (sum_limb),
      .out_CO (co_limb)
   );

   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         bx_q    <= '0;
         s_q     <= '0;
         k_q     <= '0;
         c_q     <= 1'b0;
         ov_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_VALID) begin
                  a_q     <= in_A;
                  bx_q    <= in_SUB ? ~in_B : in_B;
                  c_q     <= in_SUB | in_CI;
                  k_q     <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               s_q[{k_q, 6'd0} +: 64] <= sum_limb;
               c_q <= co_limb;
               if (k_q == K_LAST) begin
                  // Top limb: its carry stays in c_q for out_CO and never wraps to limb 0
                  k_q     <= '0;
                  ov_q    <= (a_q[W-1] == bx_q[W-1]) & (sum_limb[63] != a_q[W-1]);
                  valid_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            S_DONE: begin
               if (in_READY) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_READY = (state_q == S_IDLE);
   assign out_S     = s_q;
   assign out_CO    = c_q;
   assign out_OV    = ov_q;
   assign out_VALID = valid_q;
endmodule

// File: tb/tb_vcla_mp_seq.sv
// tb/tb_vcla_mp_seq.sv - vector table plus scoreboard bench for vcla_mp_seq (NWORDS=4)
// Expected results come from constants or a 257-bit reference add, queued at drive time.

module tb_vcla_mp_seq;
   localparam int W = 256;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ci = 1'b0;
   logic         in_sub = 1'b0;
   logic [W-1:0] out_s;
   logic         out_co;
   logic         out_ov;
   logic         out_valid;
   logic         in_ready = 1'b1;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   vcla_mp_seq #(.NWORDS(4)) dut (
      .in_CLK    (clk),
      .in_RST    (rst),
      .in_VALID  (in_valid),
      .out_READY (out_ready),
      .in_A      (in_a),
      .in_B      (in_b),
      .in_CI     (in_ci),
      .in_SUB    (in_sub),
      .out_S     (out_s),
      .out_CO    (out_co),
      .out_OV    (out_ov),
      .out_VALID (out_valid),
      .in_READY  (in_ready)
   );

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd256();
      logic [W-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic vec_t model(input vec_t v);
      logic [W:0]   r;
      logic [W-1:0] bx;
      bx   = v.sub ? ~v.b : v.b;
      r    = {1'b0, v.a} + {1'b0, bx} + (W+1)'(v.sub | v.ci);
      v.s  = r[W-1:0];
      v.co = r[W];
      v.ov = (v.a[W-1] == bx[W-1]) && (r[W-1] != v.a[W-1]);
      return v;
   endfunction

   function automatic vec_t mkvec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                  input logic sub, input logic [W-1:0] s, input logic co, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.ci = ci; v.sub = sub; v.s = s; v.co = co; v.ov = ov;
      return v;
   endfunction

   task automatic start_op(input vec_t v);
      int   w = 0;
      exp_t e;
      @(negedge clk);
      while (!out_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!out_ready) chk("ready_timeout", {255'd0, out_ready}, 1);
      in_a = v.a; in_b = v.b; in_ci = v.ci; in_sub = v.sub; in_valid = 1'b1;
      e.s = v.s; e.co = v.co; e.ov = v.ov;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic finish_op(input string nm);
      int   cyc = 0;
      exp_t e;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, cyc, 4);
      if (exp_q.size() == 0) begin
         chk({nm, "_queue"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk({nm, "_s"}, out_s, e.s);
         chk({nm, "_co"}, {255'd0, out_co}, {255'd0, e.co});
         chk({nm, "_ov"}, {255'd0, out_ov}, {255'd0, e.ov});
      end
   endtask

   initial begin
      logic [W-1:0] hold_s;
      logic         hold_co, hold_ov, stable, ready_low, seen_valid;
      vec_t         nv, v;
      logic [W-1:0] ones, max_pos, min_neg, fives;

      ones    = '1;
      max_pos = {1'b0, {(W-1){1'b1}}};
      min_neg = {1'b1, {(W-1){1'b0}}};
      fives   = {64{4'h5}};

      vecs[0] = mkvec(ones, 256'd1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      vecs[1] = mkvec('0, 256'd1, 1'b0, 1'b1, ones, 1'b0, 1'b0);
      vecs[2] = mkvec(max_pos, 256'd1, 1'b0, 1'b0, min_neg, 1'b0, 1'b1);
      vecs[3] = model(mkvec(rnd256(), rnd256(), 1'b1, 1'b0, '0, 1'b0, 1'b0));
      vecs[4] = model(mkvec(rnd256(), rnd256(), 1'b1, 1'b1, '0, 1'b0, 1'b0));
      vecs[5] = model(mkvec(min_neg, 256'd1, 1'b0, 1'b1, '0, 1'b0, 1'b0));

      // reset while idle
      repeat (3) @(negedge clk);
      chk("rst_valid", {255'd0, out_valid}, 0);
      chk("rst_s", out_s, '0);
      chk("rst_co", {255'd0, out_co}, 0);
      chk("rst_ov", {255'd0, out_ov}, 0);
      chk("rst_ready", {255'd0, out_ready}, 1);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         start_op(vecs[i]);
         finish_op($sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_drop", i), {255'd0, out_valid}, 0);
      end

      // backpressure: DONE held with a competing request on in_VALID
      v  = model(mkvec(rnd256(), rnd256(), 1'b0, 1'b0, '0, 1'b0, 1'b0));
      nv = model(mkvec(rnd256(), rnd256(), 1'b0, 1'b1, '0, 1'b0, 1'b0));
      in_ready = 1'b0;
      start_op(v);
      finish_op("bp");
      hold_s = out_s; hold_co = out_co; hold_ov = out_ov;
      in_a = nv.a; in_b = nv.b; in_ci = nv.ci; in_sub = nv.sub; in_valid = 1'b1;
      stable = 1'b1; ready_low = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_s !== hold_s || out_co !== hold_co || out_ov !== hold_ov || out_valid !== 1'b1) stable = 1'b0;
         if (out_ready !== 1'b0) ready_low = 1'b0;
      end
      chk("bp_stable", {255'd0, stable}, 1);
      chk("bp_ready_low", {255'd0, ready_low}, 1);
      in_ready = 1'b1;
      @(negedge clk);
      chk("bp_drop_valid", {255'd0, out_valid}, 0);
      chk("bp_ready_back", {255'd0, out_ready}, 1);
      exp_q.push_back('{s: nv.s, co: nv.co, ov: nv.ov});
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_accepted", {255'd0, out_ready}, 0);
      finish_op("bp_next");

      // reset after two limbs of an operation
      @(negedge clk);
      in_a = fives; in_b = fives; in_ci = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid", {255'd0, out_valid}, 0);
      chk("abort_s", out_s, '0);
      chk("abort_co", {255'd0, out_co}, 0);
      chk("abort_ov", {255'd0, out_ov}, 0);
      chk("abort_ready", {255'd0, out_ready}, 1);
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      chk("abort_no_resp", {255'd0, seen_valid}, 0);
      start_op(mkvec(256'd3, 256'd5, 1'b1, 1'b0, 256'd9, 1'b0, 1'b0));
      finish_op("post_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
